instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage sitting between the program counter block and the decoder. It reads the instruction at the current PC over a req/ack memory port and buffers up to two fetched instructions, with their PCs, for the decoder. It advances the PC by pulsing `step_pc` with `ctl`=0, which adds 4. Branch redirects from execute are handled by flushing the buffer and driving `ctl`=1 plus an offset onto the system bus, so the PC block lands on the absolute target.

## Interface
- `DEPTH`, 2: instruction buffer entries; fixed at 2, no other value supported.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc_in`  in  32  current PC value from the PC block.
- `step_pc`  out  1  PC step strobe; driven directly from a flop, one `clk` cycle wide.
- `pc_ctl`  out  1  PC mode: 0 = increment by 4, 1 = add `bus_out`.
- `bus_out`  out  32  offset placed on the system bus for redirects.
- `mem_req`  out  1  memory read request.
- `mem_addr`  out  32  read address; equals `pc_in` while `mem_req`=1.
- `mem_ack`  in  1  read data valid, single-cycle.
- `mem_rdata`  in  32  instruction word, valid when `mem_ack`=1.
- `redirect_valid`  in  1  single-cycle redirect pulse from execute.
- `redirect_target`  in  32  absolute target PC; bits [1:0] are ignored and treated as 0.
- `instr_valid`  out  1  buffer head valid.
- `instr_out`  out  32  buffer head instruction.
- `instr_pc`  out  32  buffer head PC.
- `instr_ready`  in  1  decoder accepts the head when `instr_valid` & `instr_ready`.

## Operation
- **States:** IDLE, REQ, STEP, REDIR, SETTLE.
  - IDLE: if `pend`=1, go to REDIR; else if count<2, go to REQ; else stay.
  - REQ: `mem_req`=1 and `mem_addr`=`pc_in`, held stable until `mem_ack`.
    - On ack with `discard`=0: push {`pc_in`, `mem_rdata`}, go to STEP.
    - On ack with `discard`=1: drop the data, clear `discard`, go to IDLE.
  - STEP: `step_pc`=1, `pc_ctl`=0; go to SETTLE.
  - REDIR: `step_pc`=1, `pc_ctl`=1, `bus_out` = `tgt` − `pc_in` (mod 2^32); clear `pend`; go to SETTLE.
  - SETTLE: all strobes 0; go to IDLE. This gives the PC block a full cycle to update `pc_in`.
- **Outside REDIR:** `pc_ctl`=0 and `bus_out`=0.
- **Redirect capture:** accepted in any state. On `redirect_valid`=1:
  - `tgt` ← {target[31:2], 2'b00}, `pend` ← 1. A second redirect before REDIR overwrites `tgt`; the latest wins.
  - Buffer count ← 0. A same-cycle pop is ignored.
  - In REQ: `discard` ← 1 and any same-cycle `mem_ack` data is dropped, not pushed.
  - In STEP: the increment completes. The REDIR subtraction absorbs it, so no correction is needed.
- **Buffer:** 2-entry FIFO of {pc, instr}, wrapping read/write pointers, 2-bit count.
  - Head drives `instr_out`/`instr_pc`; `instr_valid` = (count≠0).
  - Pop on `instr_valid` & `instr_ready`.
  - Push and pop in the same cycle leave count unchanged.
  - Push never occurs when full, because REQ is only entered with count<2.
  - Overflow and underflow are impossible by construction; bench assertions check this.
- **Reset values:** state=IDLE; `mem_req`, `step_pc`, `pc_ctl`, `pend`, `discard`, count, pointers = 0; `bus_out`, `mem_addr`, `instr_out`, `instr_pc`, `tgt` = 0; `instr_valid`=0.
- **Reset mid-operation:** an outstanding request is abandoned and a later `mem_ack` is ignored. Memory must tolerate a dropped request after reset.

## Timing
- **First request:** reset deasserted at edge 0 puts the FSM in IDLE in cycle 0; `mem_req` rises in cycle 1.
- **Zero-wait memory** (ack in the same cycle as `mem_req`):
  - Per instruction: REQ→STEP→SETTLE→IDLE, 4 cycles.
  - `instr_valid` is high in the cycle after ack.
  - `step_pc` is high in the cycle after ack.
- **N-cycle ack latency:** adds N cycles in REQ; `mem_addr` is constant throughout.
- **Redirect from IDLE:** `redirect_valid` in cycle t gives REDIR in t+1 (`step_pc` high) and SETTLE in t+2. The next `mem_req` with `mem_addr`=`tgt` is in t+4.
- **Full buffer:** stalls in IDLE. A pop in cycle t gives REQ in t+1.

## Test plan
- **Sequential fetch:** reset, PC model starts at 0x0, zero-wait memory returns 0xA0000000+addr.
  - `instr_pc`/`instr_out` sequence is 0x0/0xA0000000, 0x4/0xA0000004, 0x8/0xA0000008.
  - One `step_pc` pulse with `pc_ctl`=0 per instruction.
- **Backpressure:** `instr_ready`=0 throughout.
  - Exactly 2 fetches occur, then `mem_req` stays 0.
  - Raising `instr_ready` for one cycle gives one pop and `mem_req` high the next cycle.
- **Redirect from idle:** pc_in=0x10, `redirect_target`=0x100.
  - REDIR drives `bus_out`=0xF0, `pc_ctl`=1.
  - Next `mem_addr`=0x100 and the buffer is empty.
- **Redirect during wait:** memory latency 3, redirect to 0x40 one cycle after `mem_req` rises.
  - The returned word is not pushed and no STEP pulse occurs.
  - Next fetch is at 0x40.
- **Backward redirect with a same-cycle collision:** pc_in=0x200, target 0x80, redirect coincident with `mem_ack` and a pop.
  - `bus_out`=0xFFFFFE80 and `instr_valid`=0 the next cycle.
  - Next fetch is at 0x80.
- **Reset mid-request:** `rst` asserted while in REQ, then a late `mem_ack`.
  - All outputs are at their reset values and no push occurs.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: fetches instructions over a req/ack port into a 2-entry buffer and
// drives PC step/redirect strobes toward the PC block.
module instr_fetch #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        step_pc,
  output logic        pc_ctl,
  output logic [31:0] bus_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);
  typedef enum logic [2:0] {IDLE, REQ, STEP, REDIR, SETTLE} state_t;
  localparam logic [1:0] FULL = 2'(DEPTH);
  state_t state_q, state_d;
  logic step_q, step_d, ctl_q, ctl_d, req_q, req_d;
  logic pend_q, pend_d, disc_q, disc_d;
  logic [31:0] bus_q, bus_d, addr_q, addr_d, tgt_q, tgt_d;
  logic [1:0] cnt_q, cnt_d;
  logic rp_q, rp_d, wp_q, wp_d;
  logic [31:0] pc_q [DEPTH];
  logic [31:0] pc_d [DEPTH];
  logic [31:0] ins_q [DEPTH];
  logic [31:0] ins_d [DEPTH];
  logic push, pop;
  assign step_pc     = step_q;
  assign pc_ctl      = ctl_q;
  assign bus_out     = bus_q;
  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign instr_valid = cnt_q != 2'd0;
  assign instr_out   = ins_q[rp_q];
  assign instr_pc    = pc_q[rp_q];
  always_comb begin
    pop = instr_valid & instr_ready & ~redirect_valid;
    push = 1'b0;
    state_d = state_q;
    step_d = 1'b0;
    ctl_d = 1'b0;
    bus_d = '0;
    req_d = req_q;
    addr_d = addr_q;
    disc_d = disc_q;
    tgt_d = redirect_valid ? (redirect_target & ~32'd3) : tgt_q;
    pend_d = redirect_valid | (pend_q & (state_q != REDIR));
    case (state_q)
      IDLE:
        if (pend_q | redirect_valid) begin
          state_d = REDIR;
          step_d = 1'b1;
          ctl_d = 1'b1;
          bus_d = tgt_d - pc_in;
        end else if (cnt_q - {1'b0, pop} < FULL) begin
          state_d = REQ;
          req_d = 1'b1;
          addr_d = pc_in;
        end
      REQ:
        if (mem_ack) begin
          // a redirect seen during or with this ack kills the returned word
          req_d = 1'b0;
          disc_d = 1'b0;
          push = ~(disc_q | redirect_valid);
          state_d = push ? STEP : IDLE;
          step_d = push;
        end else if (redirect_valid) begin
          disc_d = 1'b1;
        end
      STEP, REDIR: state_d = SETTLE;
      default: state_d = IDLE;
    endcase
    pc_d = pc_q;
    ins_d = ins_q;
    if (push) begin
      pc_d[wp_q] = pc_in;
      ins_d[wp_q] = mem_rdata;
    end
    wp_d = redirect_valid ? 1'b0 : wp_q + push;
    rp_d = redirect_valid ? 1'b0 : rp_q + pop;
    cnt_d = redirect_valid ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q <= 1'b0;
      ctl_q <= 1'b0;
      req_q <= 1'b0;
      pend_q <= 1'b0;
      disc_q <= 1'b0;
      bus_q <= '0;
      addr_q <= '0;
      tgt_q <= '0;
      cnt_q <= '0;
      rp_q <= 1'b0;
      wp_q <= 1'b0;
      pc_q <= '{default: '0};
      ins_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      ctl_q <= ctl_d;
      req_q <= req_d;
      pend_q <= pend_d;
      disc_q <= disc_d;
      bus_q <= bus_d;
      addr_q <= addr_d;
      tgt_q <= tgt_d;
      cnt_q <= cnt_d;
      rp_q <= rp_d;
      wp_q <= wp_d;
      pc_q <= pc_d;
      ins_q <= ins_d;
    end
  end
endmodule
